// File: rtl/debouncer_pkg.sv
// Shared debounce timing helpers: glitch window in clock cycles and the
// counter width needed to hold it. Also used by the single-key debouncer.
package debouncer_pkg;

  // Glitch window in cycles; never below one so the filter always exists.
  function automatic int glitch_cycles(input int freq_mhz, input int time_ns);
    int cyc;
    cyc = (time_ns * freq_mhz) / 1000;
    return (cyc < 1) ? 1 : cyc;
  endfunction

  function automatic int cnt_width(input int glitch_cyc);
    return $clog2(glitch_cyc + 1);
  endfunction

endpackage

// File: rtl/debouncer_bank_if.sv
// Key bus between raw board inputs and the debouncer bank outputs.
// The master drives raw keys; the slave (the bank) drives the filtered view.
interface debouncer_bank_if #(
  parameter int CHANNELS = 4
);
  logic [CHANNELS-1:0] key_i;
  logic [CHANNELS-1:0] key_state_o;
  logic [CHANNELS-1:0] key_pressed_stb_o;
  logic [CHANNELS-1:0] key_released_stb_o;
  logic                any_pressed_o;

  modport master (
    output key_i,
    input  key_state_o,
    input  key_pressed_stb_o,
    input  key_released_stb_o,
    input  any_pressed_o
  );

  modport slave (
    input  key_i,
    output key_state_o,
    output key_pressed_stb_o,
    output key_released_stb_o,
    output any_pressed_o
  );
endinterface

// File: rtl/debouncer_channel.sv
// One debounced key: synchroniser, consecutive-sample counter, stable level
// and registered press/release strobes. Input is polarity-normalised (1 = pressed).
module debouncer_channel
  import debouncer_pkg::*;
#(
  parameter int CLK_FREQ_MHZ   = 100,
  parameter int GLITCH_TIME_NS = 100,
  parameter int SYNC_STAGES    = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic key_i,
  output logic key_state_o,
  output logic key_pressed_stb_o,
  output logic key_released_stb_o
);

  localparam int GLITCH_CYC = glitch_cycles(CLK_FREQ_MHZ, GLITCH_TIME_NS);
  localparam int CNT_W      = cnt_width(GLITCH_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(GLITCH_CYC - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_stable;
  logic                   r_press_stb;
  logic                   r_release_stb;
  logic                   w_key_sync;

  // NOTE: the synchroniser is reset to "released" so a key held idle through
  // reset release never looks like a change; flops use <= so every stage
  // samples the pre-edge value of the one before it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], key_i};
    end
  end

  assign w_key_sync = r_sync[SYNC_STAGES-1];

  // A change is accepted only after GLITCH_CYC consecutive differing samples.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt         <= '0;
      r_stable      <= 1'b0;
      r_press_stb   <= 1'b0;
      r_release_stb <= 1'b0;
    end else begin
      r_press_stb   <= 1'b0;
      r_release_stb <= 1'b0;
      if (w_key_sync == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_cnt         <= '0;
        r_stable      <= w_key_sync;
        r_press_stb   <= w_key_sync;
        r_release_stb <= ~w_key_sync;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign key_state_o        = r_stable;
  assign key_pressed_stb_o  = r_press_stb;
  assign key_released_stb_o = r_release_stb;

endmodule

// File: rtl/debouncer_bank.sv
// Bank of independent key debouncers: normalises key polarity, filters each
// channel and reports whether any key is currently held.
module debouncer_bank
  import debouncer_pkg::*;
#(
  parameter int   CHANNELS       = 4,
  parameter int   CLK_FREQ_MHZ   = 100,
  parameter int   GLITCH_TIME_NS = 100,
  parameter logic KEY_ACTIVE     = 1'b1,
  parameter int   SYNC_STAGES    = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  debouncer_bank_if.slave  bus
);

  logic [CHANNELS-1:0] w_key_norm;

  // Pull-up buttons read 0 when pressed; flip them so 1 always means pressed.
  assign w_key_norm = bus.key_i ^ {CHANNELS{~KEY_ACTIVE}};

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    debouncer_channel #(
      .CLK_FREQ_MHZ  (CLK_FREQ_MHZ),
      .GLITCH_TIME_NS(GLITCH_TIME_NS),
      .SYNC_STAGES   (SYNC_STAGES)
    ) u_channel (
      .clk_i             (clk_i),
      .rst_i             (rst_i),
      .key_i             (w_key_norm[g]),
      .key_state_o       (bus.key_state_o[g]),
      .key_pressed_stb_o (bus.key_pressed_stb_o[g]),
      .key_released_stb_o(bus.key_released_stb_o[g])
    );
  end

  assign bus.any_pressed_o = |bus.key_state_o;

endmodule

// File: tb/tb_debouncer_bank.sv
// Directed and soak bench for debouncer_bank: an active-high bank checked
// cycle by cycle against a run-length reference, plus an active-low bank.
module tb_debouncer_bank;

  localparam int GLITCH = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  debouncer_bank_if #(.CHANNELS(4)) bus_a ();
  debouncer_bank_if #(.CHANNELS(4)) bus_b ();

  debouncer_bank #(.KEY_ACTIVE(1'b1)) dut_a (.clk_i(clk), .rst_i(rst), .bus(bus_a.slave));
  debouncer_bank #(.KEY_ACTIVE(1'b0)) dut_b (.clk_i(clk), .rst_i(rst), .bus(bus_b.slave));

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Strobe counters taken from the DUT outputs mid-cycle.
  int pa[4] = '{default: 0};
  int ra[4] = '{default: 0};
  int pb = 0;
  int rb = 0;
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (bus_a.key_pressed_stb_o[i])  pa[i] <= pa[i] + 1;
      if (bus_a.key_released_stb_o[i]) ra[i] <= ra[i] + 1;
    end
    if (bus_b.key_pressed_stb_o[0])  pb <= pb + 1;
    if (bus_b.key_released_stb_o[0]) rb <= rb + 1;
  end

  // Reference for bank A: a level is accepted once the twice-delayed input has
  // held one value for GLITCH consecutive edges and differs from the accepted level.
  logic [3:0] m_h0, m_h1, m_prev, m_st, m_pr, m_rl;
  int m_run[4];
  int m_events = 0;
  always @(posedge clk or posedge rst) begin : model
    logic [3:0] d, n_st, n_pr, n_rl;
    int n_run[4];
    int ev;
    if (rst) begin
      m_h0 <= '0; m_h1 <= '0; m_prev <= '0;
      m_st <= '0; m_pr <= '0; m_rl <= '0;
      for (int i = 0; i < 4; i++) m_run[i] <= 0;
    end else begin
      d = m_h1; n_st = m_st; n_pr = '0; n_rl = '0; ev = 0;
      for (int i = 0; i < 4; i++) begin
        n_run[i] = (d[i] == m_prev[i]) ? m_run[i] + 1 : 1;
        if (n_run[i] > 1000) n_run[i] = 1000;
        if (d[i] != m_st[i] && n_run[i] >= GLITCH) begin
          n_st[i] = d[i];
          n_pr[i] = d[i];
          n_rl[i] = ~d[i];
          ev++;
        end
      end
      m_prev <= d; m_h1 <= m_h0; m_h0 <= bus_a.key_i;
      m_st <= n_st; m_pr <= n_pr; m_rl <= n_rl;
      for (int i = 0; i < 4; i++) m_run[i] <= n_run[i];
      m_events <= m_events + ev;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    check("cycle_a",
          {bus_a.key_state_o, bus_a.key_pressed_stb_o, bus_a.key_released_stb_o, bus_a.any_pressed_o},
          {m_st, m_pr, m_rl, |m_st});
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  int base_dut, base_model;

  initial begin
    bus_a.key_i = 4'h0;
    bus_b.key_i = 4'hF;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_a", {bus_a.key_state_o, bus_a.key_pressed_stb_o, bus_a.key_released_stb_o, bus_a.any_pressed_o}, 0);
    check("rst_out_b", {bus_b.key_state_o, bus_b.key_pressed_stb_o, bus_b.key_released_stb_o, bus_b.any_pressed_o}, 0);

    // 1: idle after reset release, no strobes on either bank
    rst = 1'b0;
    tick_n(50);
    check("idle_state_a", bus_a.key_state_o, 0);
    check("idle_strobes_a", pa[0] + pa[1] + pa[2] + pa[3] + ra[0] + ra[1] + ra[2] + ra[3], 0);
    check("idle_strobes_b", pb + rb, 0);
    check("idle_state_b", bus_b.key_state_o, 0);

    // 2: ch0 clean press then release
    bus_a.key_i[0] = 1'b1;
    tick_n(11);
    check("t2_before_press", {bus_a.key_state_o, bus_a.key_pressed_stb_o}, 0);
    tick();
    check("t2_press_stb", bus_a.key_pressed_stb_o, 4'b0001);
    check("t2_state", bus_a.key_state_o, 4'b0001);
    check("t2_any", bus_a.any_pressed_o, 1);
    tick();
    check("t2_press_one_cycle", bus_a.key_pressed_stb_o, 0);
    tick_n(17);
    bus_a.key_i[0] = 1'b0;
    tick_n(11);
    check("t2_held", bus_a.key_state_o, 4'b0001);
    tick();
    check("t2_release_stb", bus_a.key_released_stb_o, 4'b0001);
    check("t2_released_state", bus_a.key_state_o, 0);
    tick_n(18);
    check("t2_press_count", pa[0], 1);
    check("t2_release_count", ra[0], 1);
    check("t2_others_silent", pa[1] + pa[2] + pa[3] + ra[1] + ra[2] + ra[3], 0);

    // 3: ch1 bounce rejected, then a 10-cycle press accepted
    bus_a.key_i[1] = 1'b1; tick_n(9);
    bus_a.key_i[1] = 1'b0; tick_n(1);
    bus_a.key_i[1] = 1'b1; tick_n(9);
    bus_a.key_i[1] = 1'b0; tick_n(20);
    check("t3_bounce_no_press", pa[1], 0);
    check("t3_bounce_state", bus_a.key_state_o[1], 0);
    bus_a.key_i[1] = 1'b1; tick_n(10);
    bus_a.key_i[1] = 1'b0; tick_n(20);
    check("t3_press_count", pa[1], 1);
    check("t3_release_count", ra[1], 1);

    // 4: all channels pressed on the same edge
    bus_a.key_i = 4'hF;
    tick_n(11);
    tick();
    check("t4_all_press", bus_a.key_pressed_stb_o, 4'hF);
    check("t4_any", bus_a.any_pressed_o, 1);
    tick_n(10);
    bus_a.key_i = 4'h0;
    tick_n(15);
    check("t4_all_released", bus_a.key_state_o, 0);

    // 5: active-low bank, ch0 driven low for 20 cycles
    bus_b.key_i = 4'hE;
    tick_n(11);
    check("t5_before_press", bus_b.key_pressed_stb_o, 0);
    tick();
    check("t5_press_stb", bus_b.key_pressed_stb_o, 4'b0001);
    check("t5_state", {bus_b.key_state_o, bus_b.any_pressed_o}, {4'b0001, 1'b1});
    tick_n(8);
    bus_b.key_i = 4'hF;
    tick_n(15);
    check("t5_press_count", pb, 1);
    check("t5_release_count", rb, 1);

    // 6: reset mid-count and during a strobe, key held across release
    bus_a.key_i[2] = 1'b1;
    tick_n(7);
    rst = 1'b1;
    #1;
    check("t6_midcount_rst", {bus_a.key_state_o, bus_a.key_pressed_stb_o, bus_a.key_released_stb_o}, 0);
    tick_n(2);
    rst = 1'b0;
    tick_n(11);
    check("t6_no_early_press", bus_a.key_pressed_stb_o, 0);
    tick();
    check("t6_fresh_press", bus_a.key_pressed_stb_o, 4'b0100);
    rst = 1'b1;
    #1;
    check("t6_strobe_rst", {bus_a.key_state_o, bus_a.key_pressed_stb_o, bus_a.any_pressed_o}, 0);
    tick_n(2);
    rst = 1'b0;
    tick_n(11);
    tick();
    check("t6_fresh_press_2", bus_a.key_pressed_stb_o, 4'b0100);
    bus_a.key_i = 4'h0;
    tick_n(15);

    // soak: random bounces on all channels
    base_dut   = pa[0] + pa[1] + pa[2] + pa[3] + ra[0] + ra[1] + ra[2] + ra[3];
    base_model = m_events;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 5) == 0) begin
        int ch;
        ch = int'($urandom_range(0, 3));
        bus_a.key_i[ch] = ~bus_a.key_i[ch];
      end
      tick();
    end
    bus_a.key_i = 4'h0;
    tick_n(20);
    check("soak_strobe_total",
          pa[0] + pa[1] + pa[2] + pa[3] + ra[0] + ra[1] + ra[2] + ra[3] - base_dut,
          m_events - base_model);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
